// File: rtl/alu_share_arbiter.sv
// Arbitrates two valid/ready requesters onto one shared ALU: operands are
// registered into the ALU, the result is captured a cycle later and returned to its owner.
//
// state | meaning
// IDLE  | nothing in flight; grant decided combinationally from request valids
// EXEC  | ALU inputs registered and stable; result captured at end of cycle
// RESP  | owner's response valid, held stable until the owner's resp ready
module alu_share_arbiter #(
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       CTRL_W    = 4,
   parameter logic [CTRL_W-1:0] IDLE_CTRL = '0,
   parameter bit                FAIR      = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_i,

   input  logic              req0_valid_i,
   output logic              req0_ready_o,
   input  logic [DATA_W-1:0] req0_src0_i,
   input  logic [DATA_W-1:0] req0_src1_i,
   input  logic [CTRL_W-1:0] req0_ctrl_i,
   output logic              resp0_valid_o,
   input  logic              resp0_ready_i,
   output logic [DATA_W-1:0] resp0_result_o,
   output logic              resp0_zero_o,

   input  logic              req1_valid_i,
   output logic              req1_ready_o,
   input  logic [DATA_W-1:0] req1_src0_i,
   input  logic [DATA_W-1:0] req1_src1_i,
   input  logic [CTRL_W-1:0] req1_ctrl_i,
   output logic              resp1_valid_o,
   input  logic              resp1_ready_i,
   output logic [DATA_W-1:0] resp1_result_o,
   output logic              resp1_zero_o,

   output logic [DATA_W-1:0] alu_src0_o,
   output logic [DATA_W-1:0] alu_src1_o,
   output logic [CTRL_W-1:0] alu_ctrl_o,
   input  logic [DATA_W-1:0] alu_result_i,
   output logic              busy_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic                r_owner;
   logic                r_last_grant;
   logic [DATA_W-1:0]   r_alu_src0;
   logic [DATA_W-1:0]   r_alu_src1;
   logic [CTRL_W-1:0]   r_alu_ctrl;
   logic                r_resp0_valid;
   logic                r_resp1_valid;
   logic [DATA_W-1:0]   r_resp0_result;
   logic [DATA_W-1:0]   r_resp1_result;
   logic                r_resp0_zero;
   logic                r_resp1_zero;

   logic                w_accept;
   logic                w_grant1;
   logic                w_resp_hs;
   logic                w_ready0;
   logic                w_ready1;
   logic                w_busy;

   // Tie goes to the requester not served last time when FAIR, else to req0.
   assign w_grant1  = req1_valid_i & (~req0_valid_i | (FAIR & ~r_last_grant));
   assign w_accept  = ~rst_i & (r_state == ST_IDLE) & (req0_valid_i | req1_valid_i);
   assign w_resp_hs = (r_state == ST_RESP) & (r_owner ? resp1_ready_i : resp0_ready_i);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_accept)  w_state_nxt = ST_EXEC;
         ST_EXEC:                w_state_nxt = ST_RESP;
         ST_RESP: if (w_resp_hs) w_state_nxt = ST_IDLE;
         default:                w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_ready0 = 1'b0;
      w_ready1 = 1'b0;
      w_busy   = (r_state != ST_IDLE);
      if (w_accept) begin
         w_ready0 = ~w_grant1;
         w_ready1 = w_grant1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_owner        <= 1'b0;
         r_last_grant   <= 1'b1;
         r_alu_src0     <= '0;
         r_alu_src1     <= '0;
         r_alu_ctrl     <= IDLE_CTRL;
         r_resp0_valid  <= 1'b0;
         r_resp1_valid  <= 1'b0;
         r_resp0_result <= '0;
         r_resp1_result <= '0;
         r_resp0_zero   <= 1'b0;
         r_resp1_zero   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_owner      <= w_grant1;
                  r_last_grant <= w_grant1;
                  r_alu_src0   <= w_grant1 ? req1_src0_i : req0_src0_i;
                  r_alu_src1   <= w_grant1 ? req1_src1_i : req0_src1_i;
                  r_alu_ctrl   <= w_grant1 ? req1_ctrl_i : req0_ctrl_i;
               end
            end
            ST_EXEC: begin
               // Zero flag is derived here; the ALU's own zero output is not trusted.
               if (r_owner) begin
                  r_resp1_result <= alu_result_i;
                  r_resp1_zero   <= ~|alu_result_i;
                  r_resp1_valid  <= 1'b1;
               end else begin
                  r_resp0_result <= alu_result_i;
                  r_resp0_zero   <= ~|alu_result_i;
                  r_resp0_valid  <= 1'b1;
               end
            end
            ST_RESP: begin
               if (w_resp_hs) begin
                  r_resp0_valid <= 1'b0;
                  r_resp1_valid <= 1'b0;
                  r_alu_ctrl    <= IDLE_CTRL;
               end
            end
            default: ;
         endcase
      end
   end

   assign req0_ready_o   = w_ready0;
   assign req1_ready_o   = w_ready1;
   assign busy_o         = w_busy;
   assign alu_src0_o     = r_alu_src0;
   assign alu_src1_o     = r_alu_src1;
   assign alu_ctrl_o     = r_alu_ctrl;
   assign resp0_valid_o  = r_resp0_valid;
   assign resp1_valid_o  = r_resp1_valid;
   assign resp0_result_o = r_resp0_result;
   assign resp1_result_o = r_resp1_result;
   assign resp0_zero_o   = r_resp0_zero;
   assign resp1_zero_o   = r_resp1_zero;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: instance 0 is round-robin, instance 1 fixed priority,
// each with its own behavioural ALU; a negedge monitor scores against a rule-level model.
`timescale 1ns/1ps
module tb_alu_share_arbiter;

   localparam logic [3:0] OP_AND = 4'b0111, OP_OR  = 4'b0001, OP_ADD = 4'b0010,
                          OP_SUB = 4'b0011, OP_SLT = 4'b0100, OP_XOR = 4'b0101,
                          OP_SLL = 4'b0110;

   typedef struct packed {
      logic [31:0] res;
      logic        zero;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // [d][n]: d = instance (0 fair, 1 fixed), n = requester
   logic        req_valid   [2][2];
   logic        req_ready   [2][2];
   logic [31:0] req_src0    [2][2];
   logic [31:0] req_src1    [2][2];
   logic [3:0]  req_ctrl    [2][2];
   logic        resp_valid  [2][2];
   logic        resp_ready  [2][2];
   logic [31:0] resp_result [2][2];
   logic        resp_zero   [2][2];
   logic [31:0] alu_src0    [2];
   logic [31:0] alu_src1    [2];
   logic [3:0]  alu_ctrl    [2];
   logic [31:0] alu_result  [2];
   logic        busy        [2];

   // rule-level model state, written only by the stimulus process
   logic m_pending [2];
   int   m_age     [2];
   int   m_owner   [2];
   logic m_last    [2];
   exp_t sb_q      [2][$];

   int   n_vec = 0;
   int   n_err = 0;
   int   timeouts = 0;
   logic tb_done = 1'b0;

   function automatic logic [31:0] alu_fn(logic [3:0] c, logic [31:0] a, logic [31:0] b);
      case (c)
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         OP_XOR:  return a ^ b;
         OP_SLL:  return a << b[4:0];
         default: return b;
      endcase
   endfunction

   assign alu_result[0] = alu_fn(alu_ctrl[0], alu_src0[0], alu_src1[0]);
   assign alu_result[1] = alu_fn(alu_ctrl[1], alu_src0[1], alu_src1[1]);

   alu_share_arbiter #(.DATA_W(32), .CTRL_W(4), .IDLE_CTRL(4'b0000), .FAIR(1'b1)) u_fair (
      .clk_i(clk), .rst_i(rst),
      .req0_valid_i(req_valid[0][0]), .req0_ready_o(req_ready[0][0]),
      .req0_src0_i(req_src0[0][0]), .req0_src1_i(req_src1[0][0]), .req0_ctrl_i(req_ctrl[0][0]),
      .resp0_valid_o(resp_valid[0][0]), .resp0_ready_i(resp_ready[0][0]),
      .resp0_result_o(resp_result[0][0]), .resp0_zero_o(resp_zero[0][0]),
      .req1_valid_i(req_valid[0][1]), .req1_ready_o(req_ready[0][1]),
      .req1_src0_i(req_src0[0][1]), .req1_src1_i(req_src1[0][1]), .req1_ctrl_i(req_ctrl[0][1]),
      .resp1_valid_o(resp_valid[0][1]), .resp1_ready_i(resp_ready[0][1]),
      .resp1_result_o(resp_result[0][1]), .resp1_zero_o(resp_zero[0][1]),
      .alu_src0_o(alu_src0[0]), .alu_src1_o(alu_src1[0]), .alu_ctrl_o(alu_ctrl[0]),
      .alu_result_i(alu_result[0]), .busy_o(busy[0])
   );

   alu_share_arbiter #(.DATA_W(32), .CTRL_W(4), .IDLE_CTRL(4'b0000), .FAIR(1'b0)) u_fixed (
      .clk_i(clk), .rst_i(rst),
      .req0_valid_i(req_valid[1][0]), .req0_ready_o(req_ready[1][0]),
      .req0_src0_i(req_src0[1][0]), .req0_src1_i(req_src1[1][0]), .req0_ctrl_i(req_ctrl[1][0]),
      .resp0_valid_o(resp_valid[1][0]), .resp0_ready_i(resp_ready[1][0]),
      .resp0_result_o(resp_result[1][0]), .resp0_zero_o(resp_zero[1][0]),
      .req1_valid_i(req_valid[1][1]), .req1_ready_o(req_ready[1][1]),
      .req1_src0_i(req_src0[1][1]), .req1_src1_i(req_src1[1][1]), .req1_ctrl_i(req_ctrl[1][1]),
      .resp1_valid_o(resp_valid[1][1]), .resp1_ready_i(resp_ready[1][1]),
      .resp1_result_o(resp_result[1][1]), .resp1_zero_o(resp_zero[1][1]),
      .alu_src0_o(alu_src0[1]), .alu_src1_o(alu_src1[1]), .alu_ctrl_o(alu_ctrl[1]),
      .alu_result_i(alu_result[1]), .busy_o(busy[1])
   );

   // Arbitration rule: a lone request wins; a tie goes to ~last (fair) or to req0 (fixed).
   function automatic int winner(int d);
      if (req_valid[d][0] && req_valid[d][1]) begin
         if (d == 0) return m_last[d] ? 0 : 1;
         return 0;
      end
      return req_valid[d][1] ? 1 : 0;
   endfunction

   task automatic issue(int d, int n, logic [3:0] c, logic [31:0] a, logic [31:0] b);
      req_ctrl[d][n]  = c;
      req_src0[d][n]  = a;
      req_src1[d][n]  = b;
      req_valid[d][n] = 1'b1;
   endtask

   task automatic issue_rand(int d, int n);
      logic [31:0] a;
      logic [31:0] b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      issue(d, n, 4'($urandom_range(0, 15)), a, b);
   endtask

   // Advance one clock and update the model with what happened at that edge.
   task automatic step();
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            m_pending[d] = 1'b0;
            m_age[d]     = 0;
            m_last[d]    = 1'b1;
         end else if (!m_pending[d]) begin
            if (req_valid[d][0] || req_valid[d][1]) begin
               int   g;
               exp_t e;
               g      = winner(d);
               e.res  = alu_fn(req_ctrl[d][g], req_src0[d][g], req_src1[d][g]);
               e.zero = (e.res == 32'd0);
               sb_q[d].push_back(e);
               m_pending[d]    = 1'b1;
               m_age[d]        = 0;
               m_owner[d]      = g;
               m_last[d]       = (g == 1);
               req_valid[d][g] = 1'b0;
            end
         end else if (m_age[d] >= 1 && resp_ready[d][m_owner[d]]) begin
            m_pending[d] = 1'b0;
         end else begin
            m_age[d] = 1;
         end
      end
   endtask

   task automatic drain();
      int k;
      k = 0;
      for (int d = 0; d < 2; d++)
         for (int n = 0; n < 2; n++) resp_ready[d][n] = 1'b1;
      while ((m_pending[0] || m_pending[1] || req_valid[0][0] || req_valid[0][1] ||
              req_valid[1][0] || req_valid[1][1]) && k < 100) begin
         step();
         k++;
      end
      if (k >= 100) timeouts++;
      step();
   endtask

   task automatic chk(string nm, int d, int n, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s inst%0d req%0d: got %h expected %h at %0t", nm, d, n, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (rst) begin
            chk("rst_busy", d, 0, 32'(busy[d]), 32'd0);
            chk("rst_alu_ctrl", d, 0, 32'(alu_ctrl[d]), 32'd0);
            chk("rst_alu_src0", d, 0, alu_src0[d], 32'd0);
            chk("rst_alu_src1", d, 0, alu_src1[d], 32'd0);
            for (int n = 0; n < 2; n++) begin
               chk("rst_req_ready", d, n, 32'(req_ready[d][n]), 32'd0);
               chk("rst_resp_valid", d, n, 32'(resp_valid[d][n]), 32'd0);
               chk("rst_resp_zero", d, n, 32'(resp_zero[d][n]), 32'd0);
               chk("rst_resp_result", d, n, resp_result[d][n], 32'd0);
            end
            sb_q[d].delete();
         end else begin
            chk("busy", d, 0, 32'(busy[d]), 32'(m_pending[d]));
            if (!m_pending[d]) chk("idle_alu_ctrl", d, 0, 32'(alu_ctrl[d]), 32'd0);
            for (int n = 0; n < 2; n++) begin
               logic er;
               er = m_pending[d] && (m_age[d] >= 1) && (m_owner[d] == n);
               chk("req_ready", d, n, 32'(req_ready[d][n]),
                   32'(!m_pending[d] && req_valid[d][n] && (winner(d) == n)));
               chk("resp_valid", d, n, 32'(resp_valid[d][n]), 32'(er));
               if (er && resp_valid[d][n]) begin
                  if (sb_q[d].size() == 0) begin
                     chk("scoreboard_empty", d, n, 32'd0, 32'd1);
                  end else begin
                     chk("resp_result", d, n, resp_result[d][n], sb_q[d][0].res);
                     chk("resp_zero", d, n, 32'(resp_zero[d][n]), 32'(sb_q[d][0].zero));
                     if (resp_ready[d][n]) void'(sb_q[d].pop_front());
                  end
               end
            end
         end
      end
      if (tb_done) begin
         chk("timeouts", 0, 0, 32'(timeouts), 32'd0);
         chk("sb_leftover", 0, 0, 32'(sb_q[0].size()), 32'd0);
         chk("sb_leftover", 1, 0, 32'(sb_q[1].size()), 32'd0);
         $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
         $finish;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt0 [2];
      for (int d = 0; d < 2; d++) begin
         m_pending[d] = 1'b0;
         m_age[d]     = 0;
         m_owner[d]   = 0;
         m_last[d]    = 1'b1;
         cnt0[d]      = 0;
         for (int n = 0; n < 2; n++) begin
            req_valid[d][n]  = 1'b0;
            req_src0[d][n]   = '0;
            req_src1[d][n]   = '0;
            req_ctrl[d][n]   = '0;
            resp_ready[d][n] = 1'b0;
         end
      end
      #2 rst = 1'b1;
      step();
      step();
      rst = 1'b0;

      // lone ADD 5,7 -> 12
      for (int d = 0; d < 2; d++) issue(d, 0, OP_ADD, 32'd5, 32'd7);
      drain();

      // fresh reset, then a tie: SUB 9,9 (zero) vs SLT -1,1
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         issue(d, 0, OP_SUB, 32'd9, 32'd9);
         issue(d, 1, OP_SLT, 32'hFFFF_FFFF, 32'd1);
      end
      drain();
      for (int d = 0; d < 2; d++) begin
         issue(d, 0, OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF);
         issue(d, 1, OP_OR, 32'h0000_1000, 32'h0000_0001);
      end
      drain();

      // response back-pressure with a second request waiting
      issue(0, 0, OP_ADD, 32'd100, 32'd23);
      resp_ready[0][0] = 1'b0;
      step();
      step();
      issue(0, 1, OP_XOR, 32'hAAAA_5555, 32'h0F0F_0F0F);
      for (int i = 0; i < 4; i++) step();
      drain();

      // continuous contention for six req0 ops
      for (int d = 0; d < 2; d++) begin
         issue_rand(d, 0);
         issue_rand(d, 1);
         cnt0[d] = 1;
      end
      for (int i = 0; i < 40; i++) begin
         step();
         for (int d = 0; d < 2; d++) begin
            if (!req_valid[d][0] && cnt0[d] < 6) begin
               issue_rand(d, 0);
               cnt0[d]++;
            end
         end
      end
      drain();

      // reset during EXEC of a req1 XOR drops it; then OR 0xF0,0x0F
      for (int d = 0; d < 2; d++) issue(d, 1, OP_XOR, 32'h1234_5678, 32'h0000_00FF);
      step();
      #1 rst = 1'b1;
      step();
      rst = 1'b0;
      for (int d = 0; d < 2; d++) issue(d, 0, OP_OR, 32'h0000_00F0, 32'h0000_000F);
      drain();

      // shift to the top bit, and an undecoded op code passing src1
      for (int d = 0; d < 2; d++) issue(d, 0, OP_SLL, 32'd1, 32'd31);
      drain();
      for (int d = 0; d < 2; d++) issue(d, 1, 4'b1111, 32'h1234_5678, 32'hDEAD_BEEF);
      drain();

      for (int i = 0; i < 400; i++) begin
         step();
         for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 2; n++) begin
               if (!req_valid[d][n] && $urandom_range(0, 2) == 0) issue_rand(d, n);
               resp_ready[d][n] = ($urandom_range(0, 3) != 0);
            end
         end
      end
      drain();
      tb_done = 1'b1;
   end

endmodule
